// File: rtl/phase_extractor.sv
// phase_extractor: iterative CORDIC in vectoring mode. Converts one signed I/Q
// sample into a modulo-2**PHASE_BITS angle and a CORDIC-gain-scaled magnitude.
module phase_extractor #(
   parameter int DATA_BITS  = 12,
   parameter int PHASE_BITS = 10,
   parameter int ITERATIONS = 10
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic signed [DATA_BITS-1:0] i_i,
   input  logic signed [DATA_BITS-1:0] q_i,
   input  logic                        valid_i,
   output logic                        ready_o,
   output logic [PHASE_BITS-1:0]       phase_o,
   output logic [DATA_BITS+1:0]        mag_o,
   output logic                        valid_o,
   input  logic                        ready_i
);

   localparam int  XW = DATA_BITS + 3;
   localparam int  CW = $clog2(ITERATIONS);
   localparam real PI = 3.14159265358979323846;
   localparam logic [PHASE_BITS-1:0] HALF_TURN = {1'b1, {(PHASE_BITS-1){1'b0}}};

   // atan(2**-k) in phase LSBs; arctan series for k>=1 (argument <= 0.5 converges fast)
   function automatic logic [PHASE_BITS-1:0] atan_entry(input int k);
      real t;
      real p;
      real s;
      real scale;
      t = 1.0;
      for (int j = 0; j < k; j++) begin
         t = t / 2.0;
      end
      s = 0.0;
      p = t;
      if (k == 0) begin
         s = PI / 4.0;
      end else begin
         for (int n = 0; n < 40; n++) begin
            if (n % 2 == 0) begin
               s = s + p / real'(2 * n + 1);
            end else begin
               s = s - p / real'(2 * n + 1);
            end
            p = p * t * t;
         end
      end
      scale = 1.0;
      for (int j = 0; j < PHASE_BITS; j++) begin
         scale = scale * 2.0;
      end
      return PHASE_BITS'($rtoi(s * scale / (2.0 * PI) + 0.5));
   endfunction

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ROTATE = 2'd1,
      DONE   = 2'd2
   } state_t;

   logic [PHASE_BITS-1:0] atan_tab_s [ITERATIONS];

   for (genvar g = 0; g < ITERATIONS; g++) begin : g_atan
      localparam logic [PHASE_BITS-1:0] A_K = atan_entry(g);
      assign atan_tab_s[g] = A_K;
   end

   state_t                 state_q;
   logic signed [XW-1:0]   x_q, y_q;
   logic signed [XW-1:0]   x_d, y_d;
   logic [PHASE_BITS-1:0]  z_q, z_d;
   logic [CW-1:0]          k_q;
   logic                   zero_q;
   logic                   ready_q;
   logic                   valid_q;
   logic [PHASE_BITS-1:0]  phase_q;
   logic [DATA_BITS+1:0]   mag_q;

   logic signed [XW-1:0]   i_ext_s, q_ext_s;
   logic signed [XW-1:0]   x_sh_s, y_sh_s;
   logic [PHASE_BITS-1:0]  a_k_s;

   // Widen before any negation so -2**(DATA_BITS-1) cannot overflow
   assign i_ext_s = {{3{i_i[DATA_BITS-1]}}, i_i};
   assign q_ext_s = {{3{q_i[DATA_BITS-1]}}, q_i};
   assign x_sh_s  = x_q >>> k_q;
   assign y_sh_s  = y_q >>> k_q;
   assign a_k_s   = atan_tab_s[k_q];

   // One micro-rotation driving y towards zero, from the pre-update x/y
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      z_d = z_q;
      if (!y_q[XW-1]) begin
         x_d = x_q + y_sh_s;
         y_d = y_q - x_sh_s;
         z_d = z_q + a_k_s;
      end else begin
         x_d = x_q - y_sh_s;
         y_d = y_q + x_sh_s;
         z_d = z_q - a_k_s;
      end
   end

   // Control FSM, datapath registers and registered handshake/result outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         k_q     <= '0;
         zero_q  <= 1'b0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         phase_q <= '0;
         mag_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (valid_i) begin
                  // Left half-plane: rotate by 180 degrees so CORDIC starts with x >= 0
                  if (i_i[DATA_BITS-1]) begin
                     x_q <= -i_ext_s;
                     y_q <= -q_ext_s;
                     z_q <= HALF_TURN;
                  end else begin
                     x_q <= i_ext_s;
                     y_q <= q_ext_s;
                     z_q <= '0;
                  end
                  zero_q  <= (i_i == '0) && (q_i == '0);
                  k_q     <= '0;
                  ready_q <= 1'b0;
                  state_q <= ROTATE;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            ROTATE: begin
               x_q <= x_d;
               y_q <= y_d;
               z_q <= z_d;
               if (k_q == CW'(ITERATIONS - 1)) begin
                  valid_q <= 1'b1;
                  phase_q <= zero_q ? '0 : z_d;
                  mag_q   <= zero_q ? '0 : x_d[DATA_BITS+1:0];
                  state_q <= DONE;
               end else begin
                  k_q <= k_q + CW'(1);
               end
            end
            DONE: begin
               if (ready_i) begin
                  valid_q <= 1'b0;
                  ready_q <= 1'b1;
                  state_q <= IDLE;
               end else begin
                  valid_q <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign ready_o = ready_q;
   assign valid_o = valid_q;
   assign phase_o = phase_q;
   assign mag_o   = mag_q;

endmodule

// File: tb/tb_phase_extractor.sv
// Self-checking bench for phase_extractor: directed spec cases, random samples
// against a reference model, backpressure, mid-rotation reset and throughput.
module tb_phase_extractor;

   localparam int  DB      = 12;
   localparam int  PB      = 10;
   localparam int  IT      = 10;
   localparam int  PH_FULL = 1 << PB;
   localparam real PI      = 3.14159265358979323846;

   logic                 clk = 1'b0;
   logic                 rst;
   logic signed [DB-1:0] i_i, q_i;
   logic                 valid_i;
   logic                 ready_o;
   logic [PB-1:0]        phase_o;
   logic [DB+1:0]        mag_o;
   logic                 valid_o;
   logic                 ready_i;

   int errors = 0;
   int checks = 0;

   phase_extractor #(.DATA_BITS(DB), .PHASE_BITS(PB), .ITERATIONS(IT)) dut (
      .clk     (clk),
      .rst     (rst),
      .i_i     (i_i),
      .q_i     (q_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .phase_o (phase_o),
      .mag_o   (mag_o),
      .valid_o (valid_o),
      .ready_i (ready_i)
   );

   always #5 clk = ~clk;

   // Reference: vectoring CORDIC straight from the algorithm description, on plain ints
   function automatic void ref_model(input int ii, input int qq, output int ph, output int mg);
      int x, y, z, xs, ys, a;
      if (ii == 0 && qq == 0) begin
         ph = 0;
         mg = 0;
         return;
      end
      if (ii < 0) begin
         x = -ii; y = -qq; z = PH_FULL / 2;
      end else begin
         x = ii;  y = qq;  z = 0;
      end
      for (int k = 0; k < IT; k++) begin
         a  = int'($atan(1.0 / (2.0 ** k)) * real'(PH_FULL) / (2.0 * PI));
         xs = x >>> k;
         ys = y >>> k;
         if (y >= 0) begin
            x = x + ys; y = y - xs; z = z + a;
         end else begin
            x = x - ys; y = y + xs; z = z - a;
         end
      end
      ph = ((z % PH_FULL) + PH_FULL) % PH_FULL;
      mg = x & ((1 << (DB + 2)) - 1);
   endfunction

   function automatic int cdist(input int a, input int b);
      int d;
      d = (((a - b) % PH_FULL) + PH_FULL) % PH_FULL;
      if (d > PH_FULL / 2) d = PH_FULL - d;
      return d;
   endfunction

   // Presents one sample, returns its result and latency (accepting edge = cycle 1)
   task automatic run_sample(input int ii, input int qq, output int ph, output int mg, output int lat);
      int w;
      i_i = ii[DB-1:0];
      q_i = qq[DB-1:0];
      valid_i = 1'b1;
      w = 0;
      while (ready_o !== 1'b1 && w < 50) begin
         @(posedge clk); #1; w++;
      end
      @(posedge clk); #1;
      valid_i = 1'b0;
      lat = 1;
      while (valid_o !== 1'b1 && lat < 50) begin
         @(posedge clk); #1; lat++;
      end
      ph = int'(phase_o);
      mg = int'(mag_o);
      if (ready_i) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; i_i = '0; q_i = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", ready_o); end
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", valid_o); end
      checks++; if (phase_o !== '0)   begin errors++; $display("FAIL reset_phase got=%0d want=0", phase_o); end
      checks++; if (mag_o !== '0)     begin errors++; $display("FAIL reset_mag got=%0d want=0", mag_o); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      int t_i  [8] = '{1000,    0, -1000,     0, 707, -2048, -2048, 0};
      int t_q  [8] = '{   0, 1000,     0, -1000, 707,     0, -2048, 0};
      int t_ph [8] = '{   0,  256,   512,   768, 128,   512,   640, 0};
      int t_tol[8] = '{   2,    2,     2,     2,   2,     2,     2, 0};
      int ph, mg, lat, eph, emg;
      real em, diff;
      for (int n = 0; n < 8; n++) begin
         run_sample(t_i[n], t_q[n], ph, mg, lat);
         ref_model(t_i[n], t_q[n], eph, emg);
         em   = 1.6468 * $sqrt(real'(t_i[n] * t_i[n] + t_q[n] * t_q[n]));
         diff = real'(mg) - em;
         if (diff < 0.0) diff = -diff;
         checks++; if (lat != IT + 1) begin errors++; $display("FAIL dir_latency n=%0d got=%0d want=%0d", n, lat, IT + 1); end
         checks++; if (cdist(ph, t_ph[n]) > t_tol[n]) begin errors++; $display("FAIL dir_phase_acc n=%0d got=%0d want=%0d+/-%0d", n, ph, t_ph[n], t_tol[n]); end
         checks++; if (diff > 0.005 * em) begin errors++; $display("FAIL dir_mag_acc n=%0d got=%0d want=%0f+/-0.5%%", n, mg, em); end
         checks++; if (ph != eph) begin errors++; $display("FAIL dir_phase_exact n=%0d got=%0d want=%0d", n, ph, eph); end
         checks++; if (mg != emg) begin errors++; $display("FAIL dir_mag_exact n=%0d got=%0d want=%0d", n, mg, emg); end
      end
   endtask

   task automatic test_random();
      int ii, qq, ph, mg, lat, eph, emg;
      for (int n = 0; n < 40; n++) begin
         ii = int'($urandom_range(4095, 0)) - 2048;
         qq = int'($urandom_range(4095, 0)) - 2048;
         run_sample(ii, qq, ph, mg, lat);
         ref_model(ii, qq, eph, emg);
         checks++;
         if (ph != eph || mg != emg || lat != IT + 1)
         begin
            errors++;
            $display("FAIL rand (%0d,%0d) got ph=%0d mag=%0d lat=%0d want ph=%0d mag=%0d lat=%0d",
                     ii, qq, ph, mg, lat, eph, emg, IT + 1);
         end
      end
   endtask

   task automatic test_backpressure();
      int ph, mg, lat, eph, emg;
      ready_i = 1'b0;
      run_sample(-1234, 567, ph, mg, lat);
      ref_model(-1234, 567, eph, emg);
      checks++; if (ph != eph || mg != emg) begin errors++; $display("FAIL bp_result got ph=%0d mag=%0d want ph=%0d mag=%0d", ph, mg, eph, emg); end
      i_i = 12'sd100; q_i = 12'sd200; valid_i = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         checks++;
         if (valid_o !== 1'b1 || ready_o !== 1'b0 || int'(phase_o) != eph || int'(mag_o) != emg) begin
            errors++;
            $display("FAIL bp_hold c=%0d got v=%b r=%b ph=%0d mag=%0d want v=1 r=0 ph=%0d mag=%0d",
                     c, valid_o, ready_o, phase_o, mag_o, eph, emg);
         end
      end
      valid_i = 1'b0; ready_i = 1'b1;
      @(posedge clk); #1;
      checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL bp_release got v=%b r=%b want v=0 r=1", valid_o, ready_o); end
   endtask

   task automatic test_reset_mid();
      int ph, mg, lat, eph, emg;
      bit seen;
      i_i = 12'sd800; q_i = -12'sd300; valid_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_state got r=%b v=%b want r=1 v=0", ready_o, valid_o); end
      seen = 1'b0;
      for (int c = 0; c < 15; c++) begin
         @(posedge clk); #1;
         if (valid_o !== 1'b0) seen = 1'b1;
      end
      checks++; if (seen) begin errors++; $display("FAIL rst_mid_novalid got pulse want none"); end
      run_sample(-300, -900, ph, mg, lat);
      ref_model(-300, -900, eph, emg);
      checks++;
      if (ph != eph || mg != emg || lat != IT + 1) begin
         errors++;
         $display("FAIL rst_mid_next got ph=%0d mag=%0d lat=%0d want ph=%0d mag=%0d lat=%0d", ph, mg, lat, eph, emg, IT + 1);
      end
   endtask

   task automatic test_back_to_back();
      int rise[3];
      int nr, eph, emg, w;
      ref_model(300, -400, eph, emg);
      ready_i = 1'b1; i_i = 12'sd300; q_i = -12'sd400; valid_i = 1'b1;
      nr = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (valid_o === 1'b1) begin
            if (nr < 3) rise[nr] = c;
            nr++;
            checks++;
            if (ready_o !== 1'b0 || int'(phase_o) != eph || int'(mag_o) != emg) begin
               errors++;
               $display("FAIL b2b_result c=%0d got r=%b ph=%0d mag=%0d want r=0 ph=%0d mag=%0d", c, ready_o, phase_o, mag_o, eph, emg);
            end
         end
      end
      valid_i = 1'b0;
      checks++;
      if (nr != 3) begin
         errors++;
         $display("FAIL b2b_count got=%0d want=3", nr);
      end else begin
         checks++; if (rise[1] - rise[0] != IT + 2) begin errors++; $display("FAIL b2b_period1 got=%0d want=%0d", rise[1] - rise[0], IT + 2); end
         checks++; if (rise[2] - rise[1] != IT + 2) begin errors++; $display("FAIL b2b_period2 got=%0d want=%0d", rise[2] - rise[1], IT + 2); end
      end
      w = 0;
      while ((ready_o !== 1'b1 || valid_o !== 1'b0) && w < 30) begin
         @(posedge clk); #1; w++;
      end
      checks++; if (w >= 30) begin errors++; $display("FAIL b2b_drain got timeout want idle"); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/phase_extractor.md
PHASE_EXTRACTOR -- requirements
Module: phase_extractor

Interface
REQ-001 SHALL have parameter DATA_BITS, default 12: width of signed I/Q input samples.
REQ-002 SHALL have parameter PHASE_BITS, default 10: phase output width; full circle = 2**PHASE_BITS, same phase/address convention as the sine LUT.
REQ-003 SHALL have parameter ITERATIONS, default 10: CORDIC micro-rotations per sample, legal range 4..PHASE_BITS+2.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 i_i  input  DATA_BITS signed  in-phase sample.
REQ-007 q_i  input  DATA_BITS signed  quadrature sample.
REQ-008 valid_i  input  1  i_i/q_i valid.
REQ-009 ready_o  output  1  block can accept a sample.
REQ-010 phase_o  output  PHASE_BITS unsigned  angle of (i,q), modulo 2**PHASE_BITS.
REQ-011 mag_o  output  DATA_BITS+2 unsigned  CORDIC-gain-scaled magnitude (~1.6468 x |v|), unscaled.
REQ-012 valid_o  output  1  phase_o/mag_o valid.
REQ-013 ready_i  input  1  downstream accepts result.

Function
REQ-014 SHALL implement FSM states IDLE, ROTATE, DONE.
REQ-015 IDLE: ready_o=1, valid_o=0; on valid_i=1 SHALL capture inputs and go to ROTATE.
REQ-016 Capture SHALL sign-extend I/Q to DATA_BITS+3 bits before any negation (no overflow at -2**(DATA_BITS-1)).
REQ-017 Pre-rotation at capture: I<0 -> x=-I, y=-Q, z=2**(PHASE_BITS-1); else x=I, y=Q, z=0.
REQ-018 ROTATE: one micro-rotation per cycle, k=0..ITERATIONS-1; y>=0 -> x+=y>>>k, y-=x>>>k, z+=A[k]; y<0 -> x-=y>>>k, y+=x>>>k, z-=A[k]; shifts arithmetic, x/y using pre-update values.
REQ-019 A[k] SHALL be round(atan(2**-k) * 2**PHASE_BITS / (2*pi)), constant table computed at elaboration, width PHASE_BITS.
REQ-020 z arithmetic SHALL wrap modulo 2**PHASE_BITS.
REQ-021 After iteration ITERATIONS-1 SHALL enter DONE: valid_o=1, phase_o=z, mag_o=x (low DATA_BITS+2 bits), ready_o=0.
REQ-022 valid_o asserted exactly ITERATIONS+1 cycles after the accepting edge.
REQ-023 DONE: outputs SHALL hold stable until ready_i=1; on valid_o&&ready_i SHALL return to IDLE next cycle (no same-cycle re-accept).
REQ-024 ready_o SHALL be 0 in ROTATE and DONE; valid_i ignored there.
REQ-025 Input I=0 and Q=0 SHALL produce phase_o=0, mag_o=0 (explicit zero detect at capture).
REQ-026 Convention: phase 0 = +I axis, 2**(PHASE_BITS-2) = +Q axis (sin(phase) proportional to Q).
REQ-027 Accuracy: |phase error| <= 2 LSB, mag within +/-0.5% of 1.6468*|v|, for |v| >= 2**(DATA_BITS-3).
REQ-028 Throughput: one sample per ITERATIONS+2 cycles with ready_i tied high.

Reset
REQ-029 rst=1 SHALL force IDLE, ready_o=1 (from the following cycle), valid_o=0, phase_o=0, mag_o=0, clearing iteration counter and x/y/z.
REQ-030 rst SHALL take priority over valid_i/ready_i; asserting in ROTATE or DONE SHALL abandon the sample with no valid_o pulse.

Verification (DATA_BITS=12, PHASE_BITS=10, ITERATIONS=10)
REQ-031 (I=1000,Q=0) -> phase_o 0+/-2 (wrap: 1022..1023 accepted), mag_o 1647+/-8, valid_o 11 cycles after accept.
REQ-032 (0,1000)->256+/-2; (-1000,0)->512+/-2; (0,-1000)->768+/-2; (707,707)->128+/-2.
REQ-033 (I=-2048,Q=0) -> phase_o 512+/-2, mag_o 3373+/-17, no overflow; (-2048,-2048) -> 640+/-2, mag_o 4770+/-24.
REQ-034 (0,0) -> phase_o 0, mag_o 0.
REQ-035 ready_i held 0 for 20 cycles in DONE -> valid_o, phase_o, mag_o constant; ready_o=0; new valid_i ignored.
REQ-036 rst pulsed at iteration 5 -> no valid_o; next cycle ready_o=1; following sample processes correctly.
